// File: rtl/pin_input_conditioner.sv
// Input conditioner for the ATM card/PIN controller.
// Synchronizes and debounces card/code switches and emits clean digit and card events.
module pin_input_conditioner #(
    parameter int NBITS_CODE      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_BITS        = 3
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [NBITS_CODE-1:0] code_raw,
    input  logic                  card_raw,
    output logic                  card_present,
    output logic                  card_inserted,
    output logic                  card_removed,
    output logic                  digit_valid,
    output logic [NBITS_CODE-1:0] digit
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [1:0] {
        WAIT_ZERO = 2'd0,
        READY     = 2'd1,
        HELD      = 2'd2
    } state_t;

    logic [NBITS_CODE-1:0] code_s1_q, code_s2_q;
    logic                  card_s1_q, card_s2_q;

    logic [NBITS_CODE-1:0] code_cand_q, code_cand_d;
    logic [CNT_BITS-1:0]   code_cnt_q, code_cnt_d;
    logic [NBITS_CODE-1:0] code_stable_q, code_stable_d;

    logic                  card_cand_q, card_cand_d;
    logic [CNT_BITS-1:0]   card_cnt_q, card_cnt_d;
    logic                  card_stable_q, card_stable_d;

    logic                  ins_q, ins_d;
    logic                  rem_q, rem_d;

    state_t                state_q, state_d;
    logic [NBITS_CODE-1:0] digit_q, digit_d;
    logic                  dv_q, dv_d;

    // Two-flop synchronizers for the asynchronous switch inputs
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            code_s1_q <= '0;
            code_s2_q <= '0;
            card_s1_q <= 1'b0;
            card_s2_q <= 1'b0;
        end else begin
            code_s1_q <= code_raw;
            code_s2_q <= code_s1_q;
            card_s1_q <= card_raw;
            card_s2_q <= card_s1_q;
        end
    end

    // Code debounce: candidate must be seen DEBOUNCE_CYCLES times in a row
    always_comb begin
        code_cand_d   = code_cand_q;
        code_cnt_d    = code_cnt_q;
        code_stable_d = code_stable_q;
        if (code_s2_q != code_cand_q) begin
            code_cand_d = code_s2_q;
            code_cnt_d  = '0;
        end else if (code_cnt_q != CNT_MAX) begin
            code_cnt_d = code_cnt_q + CNT_ONE;
        end else begin
            code_stable_d = code_cand_q;
        end
    end

    // Card debounce plus edge pulses aligned with the stable level change
    always_comb begin
        card_cand_d   = card_cand_q;
        card_cnt_d    = card_cnt_q;
        card_stable_d = card_stable_q;
        if (card_s2_q != card_cand_q) begin
            card_cand_d = card_s2_q;
            card_cnt_d  = '0;
        end else if (card_cnt_q != CNT_MAX) begin
            card_cnt_d = card_cnt_q + CNT_ONE;
        end else begin
            card_stable_d = card_cand_q;
        end
        ins_d = card_stable_d & ~card_stable_q;
        rem_d = ~card_stable_d & card_stable_q;
    end

    // Debounce state registers
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            code_cand_q   <= '0;
            code_cnt_q    <= '0;
            code_stable_q <= '0;
            card_cand_q   <= 1'b0;
            card_cnt_q    <= '0;
            card_stable_q <= 1'b0;
            ins_q         <= 1'b0;
            rem_q         <= 1'b0;
        end else begin
            code_cand_q   <= code_cand_d;
            code_cnt_q    <= code_cnt_d;
            code_stable_q <= code_stable_d;
            card_cand_q   <= card_cand_d;
            card_cnt_q    <= card_cnt_d;
            card_stable_q <= card_stable_d;
            ins_q         <= ins_d;
            rem_q         <= rem_d;
        end
    end

    // Digit FSM: accept a nonzero code only after a zero, card removal wins
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        dv_d    = 1'b0;
        if (!card_stable_q) begin
            state_d = WAIT_ZERO;
        end else begin
            unique case (state_q)
                WAIT_ZERO: begin
                    if (code_stable_q == '0) state_d = READY;
                end
                READY: begin
                    if (code_stable_q != '0) begin
                        digit_d = code_stable_q;
                        dv_d    = 1'b1;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (code_stable_q == '0) state_d = READY;
                end
                default: state_d = WAIT_ZERO;
            endcase
        end
    end

    // Digit FSM registers
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_ZERO;
            digit_q <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            dv_q    <= dv_d;
        end
    end

    assign card_present  = card_stable_q;
    assign card_inserted = ins_q;
    assign card_removed  = rem_q;
    assign digit_valid   = dv_q;
    assign digit         = digit_q;

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Bench for pin_input_conditioner: directed switch sequences,
// expected digit/card events queued with their due cycle and checked by a monitor.
module tb_pin_input_conditioner;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [2:0] code_raw;
    logic       card_raw;
    logic       card_present;
    logic       card_inserted;
    logic       card_removed;
    logic       digit_valid;
    logic [2:0] digit;

    pin_input_conditioner #(
        .NBITS_CODE(3),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS(3)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .code_raw(code_raw),
        .card_raw(card_raw),
        .card_present(card_present),
        .card_inserted(card_inserted),
        .card_removed(card_removed),
        .digit_valid(digit_valid),
        .digit(digit)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc++;

    typedef struct {
        int         at;
        logic [2:0] d;
    } dig_t;

    typedef struct {
        int at;
        bit ins;
    } card_t;

    dig_t  dq[$];
    card_t cq[$];
    dig_t  de;
    card_t ce;

    int n_pass = 0;
    int n_tot  = 0;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    logic [2:0] exp_digit = 3'd0;
    bit         prev_dv   = 1'b0;

    // Monitor: pops expected events whenever the DUT presents a pulse
    always @(negedge clk_2) begin
        if (reset) begin
            exp_digit = 3'd0;
            prev_dv   = 1'b0;
        end
        if (digit_valid) begin
            chk("dv_back_to_back", int'(prev_dv), 0);
            if (dq.size() == 0) begin
                chk("unexpected_digit_pulse", 1, 0);
            end else begin
                de = dq.pop_front();
                chk("digit_pulse_cycle", cyc, de.at);
                chk("digit_pulse_value", int'(digit), int'(de.d));
                exp_digit = de.d;
            end
        end else if (!reset) begin
            chk("digit_held", int'(digit), int'(exp_digit));
        end
        prev_dv = digit_valid;
        if (card_inserted || card_removed) begin
            chk("ins_rem_exclusive", int'(card_inserted && card_removed), 0);
            if (cq.size() == 0) begin
                chk("unexpected_card_pulse", 1, 0);
            end else begin
                ce = cq.pop_front();
                chk("card_pulse_cycle", cyc, ce.at);
                chk("card_pulse_kind", int'(card_inserted), int'(ce.ins));
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic set_code(logic [2:0] v);
        code_raw = v;
    endtask

    task automatic press(logic [2:0] v);
        code_raw = v;
        dq.push_back('{at: cyc + 8, d: v});
    endtask

    task automatic set_card(bit v);
        card_raw = v;
        cq.push_back('{at: cyc + 7, ins: v});
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_card_present"}, int'(card_present), 0);
        chk({tag, "_card_inserted"}, int'(card_inserted), 0);
        chk({tag, "_card_removed"}, int'(card_removed), 0);
        chk({tag, "_digit_valid"}, int'(digit_valid), 0);
        chk({tag, "_digit"}, int'(digit), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        code_raw = 3'd0;
        card_raw = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        step(3);

        // 1: card insertion latency
        set_card(1'b1);
        step(7);
        chk("t1_card_present", int'(card_present), 1);
        chk("t1_card_inserted", int'(card_inserted), 1);
        step(1);
        chk("t1_inserted_low", int'(card_inserted), 0);
        chk("t1_present_hold", int'(card_present), 1);
        step(4);

        // 2: short glitch is discarded
        set_code(3'd3);
        step(2);
        set_code(3'd0);
        step(12);

        // 3: sequence 1,0,3,0,7
        press(3'd1);
        step(10);
        set_code(3'd0);
        step(10);
        press(3'd3);
        step(10);
        set_code(3'd0);
        step(10);
        press(3'd7);
        step(10);
        set_code(3'd0);
        step(10);

        // 4: direct change to another nonzero code needs a release
        press(3'd1);
        step(10);
        set_code(3'd3);
        step(12);
        chk("t4_digit_hold", int'(digit), 1);
        set_code(3'd0);
        step(10);

        // 5: removal while held, reinsertion with code still held
        press(3'd3);
        step(10);
        set_card(1'b0);
        step(7);
        chk("t5_card_removed", int'(card_removed), 1);
        chk("t5_card_absent", int'(card_present), 0);
        step(3);
        set_card(1'b1);
        step(12);
        set_code(3'd0);
        step(10);
        press(3'd7);
        step(10);
        set_code(3'd0);
        step(10);

        // 6a: reset while code debounce counter is mid-way
        set_code(3'd5);
        step(5);
        reset = 1'b1;
        #1;
        chk_all_zero("t6a");
        step(2);
        reset = 1'b0;
        cq.push_back('{at: cyc + 7, ins: 1'b1});
        step(15);
        set_code(3'd0);
        step(10);

        // 6b: reset while HELD, then a fresh press is needed
        press(3'd2);
        step(10);
        reset = 1'b1;
        #1;
        chk_all_zero("t6b");
        step(2);
        reset = 1'b0;
        cq.push_back('{at: cyc + 7, ins: 1'b1});
        step(15);
        set_code(3'd0);
        step(10);
        press(3'd6);
        step(10);
        set_code(3'd0);
        step(5);

        chk("digit_queue_drained", dq.size(), 0);
        chk("card_queue_drained", cq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
